plot_fb_writer: RTL and testbench

- Receiving end of the datapath's pixel-plot interface (plotEn, x, y, colour_out).
- Buffers plot requests in a small FIFO and converts each (x, y) to a linear 160x120 framebuffer address.
- Writes to the shared framebuffer write port only on cycles when the scanout arbiter grants it.
- Also performs a full-screen clear sweep on request, used for game reset and death screens.

---
 rtl/plot_fb_writer.sv | 158 +++++++++++++++
 tb/tb_plot_fb_writer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/plot_fb_writer.sv
// Pixel-plot sink: buffers plot requests, maps (x,y) to a linear
// framebuffer address and writes on granted cycles; also clears the screen.
module plot_fb_writer #(
  parameter int         DEPTH     = 8,
  parameter int         WIDTH_PX  = 160,
  parameter int         HEIGHT_PX = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        plotEn,
  input  logic [7:0]  x,
  input  logic [6:0]  y,
  input  logic [2:0]  colour,
  input  logic        clear_req,
  input  logic        fb_grant,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_wren,
  output logic        clear_busy,
  output logic        fifo_full,
  output logic        overflow,
  output logic        range_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [14:0] LAST = 15'(WIDTH_PX * HEIGHT_PX - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR
  } state_e;

  state_e state_q, state_d;

  logic [17:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [14:0]   clr_q, clr_d;
  logic          full_q;
  logic          ovf_q, rng_q;
  logic [14:0]   last_addr_q;
  logic [2:0]    last_data_q;

  logic          in_range, empty, full;
  logic          push, pop, ovf_drop, rng_drop;
  logic [14:0]   addr_in;
  logic [17:0]   head;
  logic          wren;
  logic [14:0]   waddr;
  logic [2:0]    wdata;

  assign in_range = (int'(x) < WIDTH_PX) && (int'(y) < HEIGHT_PX);
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  // y*160 = y*128 + y*32
  assign addr_in  = {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  assign head     = mem_q[rp_q];

  assign pop      = (state_q == DRAIN) && fb_grant && !empty;
  assign push     = plotEn && in_range && (!full || pop);
  assign ovf_drop = plotEn && in_range && full && !pop;
  assign rng_drop = plotEn && !in_range;
  assign cnt_d    = cnt_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    wren    = 1'b0;
    waddr   = last_addr_q;
    wdata   = last_data_q;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          clr_d   = '0;
        end else if (!empty || push) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop) begin
          wren  = 1'b1;
          waddr = head[17:3];
          wdata = head[2:0];
        end
        if (clear_req) begin
          state_d = CLEAR;
          clr_d   = '0;
        end else if (empty && !push) begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (fb_grant) begin
          wren  = 1'b1;
          waddr = clr_q;
          wdata = BG_COLOUR;
        end
        if (clear_req) begin
          clr_d = '0;
        end else if (fb_grant) begin
          if (clr_q == LAST) begin
            clr_d   = '0;
            state_d = (cnt_d != '0) ? DRAIN : IDLE;
          end else begin
            clr_d = clr_q + 15'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {addr_in, colour};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      clr_q       <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      rng_q       <= 1'b0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      // a drop in the same cycle as clear_req still flags
      ovf_q <= ovf_drop | (ovf_q & ~clear_req);
      rng_q <= rng_drop | (rng_q & ~clear_req);
      if (wren) begin
        last_addr_q <= waddr;
        last_data_q <= wdata;
      end
    end
  end

  assign fb_wren    = wren;
  assign fb_addr    = waddr;
  assign fb_data    = wdata;
  assign clear_busy = (state_q == CLEAR);
  assign fifo_full  = full_q;
  assign overflow   = ovf_q;
  assign range_err  = rng_q;

endmodule

// File: tb/tb_plot_fb_writer.sv
// Directed bench for plot_fb_writer; every framebuffer write is
// checked against a queue of expected {clear_busy, addr, data}.
module tb_plot_fb_writer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        plotEn;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        clear_req;
  logic        fb_grant;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_wren;
  logic        clear_busy;
  logic        fifo_full;
  logic        overflow;
  logic        range_err;

  int checks = 0;
  int errors = 0;
  logic [18:0] q[$];

  plot_fb_writer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .plotEn    (plotEn),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .clear_req (clear_req),
    .fb_grant  (fb_grant),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .fb_wren   (fb_wren),
    .clear_busy(clear_busy),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && fb_wren === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write observed addr=%0d expected none",
               fb_addr);
      end else begin
        chk("write", {13'b0, clear_busy, fb_addr, fb_data}, 32'(q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic plot(input int px, input int py, input int pc,
                      input bit expect_wr);
    plotEn = 1'b1;
    x      = 8'(px);
    y      = 7'(py);
    colour = 3'(pc);
    if (expect_wr) q.push_back({1'b0, 15'(py * 160 + px), 3'(pc)});
    cyc();
    plotEn = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      cyc();
      n++;
    end
    chk(tag, 32'(q.size()), 32'd0);
    repeat (4) cyc();
  endtask

  initial begin
    rst = 1'b1; plotEn = 1'b0; x = '0; y = '0; colour = '0;
    clear_req = 1'b0; fb_grant = 1'b0;
    #3 rst = 1'b0;
    #2;
    chk("rst_wren", 32'(fb_wren), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_data), 0);
    chk("rst_busy", 32'(clear_busy), 0);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_rng", 32'(range_err), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc();

    // single plot, one-cycle latency
    fb_grant = 1'b1;
    plot(30, 26, 1, 1'b1);
    @(negedge clk);
    chk("single_wren", 32'(fb_wren), 1);
    chk("single_addr", 32'(fb_addr), 4190);
    chk("single_data", 32'(fb_data), 1);
    cyc();
    wait_drain("single_drain", 10);

    // grant stall
    fb_grant = 1'b0;
    plot(5, 1, 2, 1'b1);
    plot(6, 2, 3, 1'b1);
    plot(7, 3, 4, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_wren", 32'(fb_wren), 0);
      chk("stall_addr", 32'(fb_addr), 4190);
      cyc();
    end
    fb_grant = 1'b1;
    repeat (3) cyc();
    chk("stall_burst", 32'(q.size()), 0);
    wait_drain("stall_drain", 10);

    // overflow
    fb_grant = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) plot(10 + i, 5, i % 8, i < DEPTH);
    @(negedge clk);
    chk("ovf_full", 32'(fifo_full), 1);
    chk("ovf_flag", 32'(overflow), 1);
    cyc();
    fb_grant = 1'b1;
    wait_drain("ovf_drain", DEPTH + 4);
    chk("ovf_full_after", 32'(fifo_full), 0);

    // range check
    plot(160, 0, 5, 1'b0);
    plot(0, 120, 5, 1'b0);
    repeat (4) cyc();
    chk("rng_flag", 32'(range_err), 1);
    chk("ovf_sticky", 32'(overflow), 1);
    plot(159, 119, 6, 1'b1);
    wait_drain("rng_corner", 10);

    // clear sweep with a plot landing during it
    clear_req = 1'b1;
    for (int i = 0; i < 19200; i++) q.push_back({1'b1, 15'(i), 3'b000});
    cyc();
    clear_req = 1'b0;
    chk("clr_busy", 32'(clear_busy), 1);
    chk("clr_flags", {30'b0, overflow, range_err}, 0);
    repeat (20) cyc();
    plot(60, 60, 2, 1'b1);
    wait_drain("clr_drain", 19400);
    chk("clr_busy_end", 32'(clear_busy), 0);

    // reset in the middle of a sweep
    clear_req = 1'b1;
    for (int i = 0; i < 5000; i++) q.push_back({1'b1, 15'(i), 3'b000});
    cyc();
    clear_req = 1'b0;
    plot(10, 10, 3, 1'b0);
    plot(11, 10, 3, 1'b0);
    repeat (4998) cyc();
    chk("mid_written", 32'(q.size()), 0);
    rst = 1'b0;
    #1;
    chk("mid_wren", 32'(fb_wren), 0);
    chk("mid_addr", 32'(fb_addr), 0);
    chk("mid_data", 32'(fb_data), 0);
    chk("mid_busy", 32'(clear_busy), 0);
    chk("mid_full", 32'(fifo_full), 0);
    repeat (2) cyc();
    rst = 1'b1;
    repeat (40) cyc();
    chk("post_busy", 32'(clear_busy), 0);
    chk("post_q", 32'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
